// File: rtl/serial_divider_8bit.sv
// rtl/serial_divider_8bit.sv - multi-cycle restoring divider, one shift-subtract step per clock
// Optional SIGNED_DIV_EN adds a Signed input for two's-complement operands.
module serial_divider_8bit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SIGNED_DIV_EN
   input  logic             Signed,
`endif
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] dsr_r;
   logic             neg_q;
   logic             neg_r;

   logic             sn_n;
   logic             sn_d;
   logic [WIDTH-1:0] mag_n;
   logic [WIDTH-1:0] mag_d;

`ifdef SIGNED_DIV_EN
   assign sn_n = Signed & Dividend[WIDTH-1];
   assign sn_d = Signed & Divisor[WIDTH-1];
`else
   assign sn_n = 1'b0;
   assign sn_d = 1'b0;
`endif

   // Magnitudes are divided unsigned; the most-negative value maps onto itself as an unsigned magnitude.
   assign mag_n = sn_n ? -Dividend : Dividend;
   assign mag_d = sn_d ? -Divisor  : Divisor;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] trial;
   logic             keep;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] q_nx;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic             unused_trial_msb;

   // Trial subtraction as an adder with inverted divisor and carry-in 1; carry-out set means non-negative.
   assign rem_sh = {rem_r, q_r[WIDTH-1]};
   assign trial  = {1'b0, rem_sh} + {1'b0, ~{1'b0, dsr_r}} + (WIDTH+2)'(1);
   assign keep   = trial[WIDTH+1];
   assign unused_trial_msb = trial[WIDTH];
   assign rem_nx = keep ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign q_nx   = {q_r[WIDTH-2:0], keep};
   assign q_fin  = neg_q ? -q_nx : q_nx;
   assign r_fin  = neg_r ? -rem_nx : rem_nx;

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         q_r         <= '0;
         rem_r       <= '0;
         dsr_r       <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         Quotient    <= '0;
         Remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  dsr_r       <= mag_d;
                  q_r         <= mag_n;
                  rem_r       <= '0;
                  cnt         <= CNT_W'(WIDTH);
                  neg_q       <= sn_n ^ sn_d;
                  neg_r       <= sn_n;
                  div_by_zero <= (Divisor == '0);
                  if (Divisor == '0) begin
                     Quotient  <= '1;
                     Remainder <= Dividend;
                     state     <= S_DONE;
                  end else begin
                     state     <= S_RUN;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               rem_r <= rem_nx;
               q_r   <= q_nx;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  Quotient  <= q_fin;
                  Remainder <= r_fin;
                  state     <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_divider_8bit.sv
// tb/tb_serial_divider_8bit.sv - directed and swept checks for serial_divider_8bit
module tb_serial_divider_8bit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] Dividend;
   logic [7:0] Divisor;
   logic [7:0] Quotient;
   logic [7:0] Remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;
`ifdef SIGNED_DIV_EN
   logic       sgn;
`endif

   int checks = 0;
   int errors = 0;

   serial_divider_8bit #(.WIDTH(8), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
`ifdef SIGNED_DIV_EN
      .Signed      (sgn),
`endif
      .Dividend    (Dividend),
      .Divisor     (Divisor),
      .Quotient    (Quotient),
      .Remainder   (Remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] n;
      logic [7:0] d;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drives one start pulse; returns one time unit after the accepting edge.
   task automatic issue(input logic [7:0] n, input logic [7:0] d);
      Dividend = n;
      Divisor  = d;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // lat = number of edges after the start edge before done is seen.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   int lat;
   int bcnt;
   int en;
   int ed;

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      Dividend = 8'd0;
      Divisor  = 8'd0;
`ifdef SIGNED_DIV_EN
      sgn      = 1'b0;
`endif
      vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
      vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
      vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
      vecs[3]  = '{8'd42,  8'd0,   8'hFF,  8'd42,  1'b1};
      vecs[4]  = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0};
      vecs[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
      vecs[6]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
      vecs[7]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
      vecs[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
      vecs[9]  = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0};
      vecs[10] = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0};
      vecs[11] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
      vecs[12] = '{8'd7,   8'd8,   8'd0,   8'd7,   1'b0};
      vecs[13] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};

      #12;
      chk("rst_q", Quotient, 0);
      chk("rst_r", Remainder, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_by_zero, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 100/7 with busy-length check
      issue(8'd100, 8'd7);
      wait_done(lat, bcnt);
      chk("first_lat", lat, 8);
      chk("first_busy_cycles", bcnt, 8);
      chk("first_q", Quotient, 14);
      chk("first_r", Remainder, 2);

      @(posedge clk);
      #1;
      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].n, vecs[i].d);
         wait_done(lat, bcnt);
         chk($sformatf("vec%0d_lat", i), lat, (vecs[i].d == 8'd0) ? 0 : 8);
         chk($sformatf("vec%0d_q", i), Quotient, vecs[i].q);
         chk($sformatf("vec%0d_r", i), Remainder, vecs[i].r);
         chk($sformatf("vec%0d_dz", i), div_by_zero, vecs[i].z);
         chk($sformatf("vec%0d_busy_at_done", i), busy, 0);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_done_pulse", i), done, 0);
      end

      // back-to-back 255/1 then 5/9 with start held in the DONE cycle
      issue(8'd255, 8'd1);
      wait_done(lat, bcnt);
      chk("b2b_a_q", Quotient, 255);
      chk("b2b_a_r", Remainder, 0);
      issue(8'd5, 8'd9);
      chk("b2b_busy_no_idle", busy, 1);
      chk("b2b_done_single", done, 0);
      wait_done(lat, bcnt);
      chk("b2b_b_lat", lat, 8);
      chk("b2b_b_q", Quotient, 0);
      chk("b2b_b_r", Remainder, 5);
      @(posedge clk);
      #1;
      chk("b2b_b_done_single", done, 0);

      // divide by zero then flag clears on the next op
      issue(8'd42, 8'd0);
      wait_done(lat, bcnt);
      chk("dz_lat", lat, 0);
      chk("dz_q", Quotient, 8'hFF);
      chk("dz_r", Remainder, 42);
      chk("dz_flag", div_by_zero, 1);
      @(posedge clk);
      #1;
      chk("dz_flag_held", div_by_zero, 1);
      issue(8'd10, 8'd3);
      chk("dz_clear_on_start", div_by_zero, 0);
      wait_done(lat, bcnt);
      chk("dz_next_q", Quotient, 3);
      chk("dz_next_r", Remainder, 1);

      // start during RUN is ignored
      @(posedge clk);
      #1;
      issue(8'd200, 8'd13);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("run_q_stable", Quotient, 3);
      issue(8'd9, 8'd2);
      chk("ign_busy", busy, 1);
      wait_done(lat, bcnt);
      chk("ign_lat", lat + 3, 8);
      chk("ign_q", Quotient, 15);
      chk("ign_r", Remainder, 5);

      // asynchronous reset mid-operation
      @(posedge clk);
      #1;
      issue(8'd200, 8'd13);
      @(posedge clk);
      #1;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_q", Quotient, 0);
      chk("mid_rst_r", Remainder, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_dz", div_by_zero, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      issue(8'd9, 8'd2);
      wait_done(lat, bcnt);
      chk("post_rst_lat", lat, 8);
      chk("post_rst_q", Quotient, 4);
      chk("post_rst_r", Remainder, 1);

      // sweep with a reference quotient/remainder computed here
      for (int i = 0; i < 1000; i++) begin
         en = $urandom_range(0, 255);
         ed = $urandom_range(0, 255);
         if (i % 97 == 0) ed = 0;
         if (i % 89 == 0) ed = en;
         @(posedge clk);
         #1;
         issue(8'(en), 8'(ed));
         wait_done(lat, bcnt);
         if (ed == 0) begin
            chk("sweep_dz_q", Quotient, 8'hFF);
            chk("sweep_dz_r", Remainder, en);
            chk("sweep_dz_flag", div_by_zero, 1);
            chk("sweep_dz_lat", lat, 0);
         end else begin
            chk($sformatf("sweep_q_%0d_%0d", en, ed), Quotient, en / ed);
            chk($sformatf("sweep_r_%0d_%0d", en, ed), Remainder, en % ed);
            chk("sweep_lat", lat, 8);
         end
      end

`ifdef SIGNED_DIV_EN
      @(posedge clk);
      #1 sgn = 1'b1;
      issue(8'h9C, 8'd7);
      wait_done(lat, bcnt);
      chk("s_neg_pos_q", Quotient, 8'hF2);
      chk("s_neg_pos_r", Remainder, 8'hFE);
      chk("s_lat", lat, 8);
      @(posedge clk);
      #1;
      issue(8'd100, 8'hF9);
      wait_done(lat, bcnt);
      chk("s_pos_neg_q", Quotient, 8'hF2);
      chk("s_pos_neg_r", Remainder, 8'h02);
      @(posedge clk);
      #1;
      issue(8'h80, 8'hFF);
      wait_done(lat, bcnt);
      chk("s_ovf_q", Quotient, 8'h80);
      chk("s_ovf_r", Remainder, 8'h00);
      chk("s_ovf_dz", div_by_zero, 0);
      @(posedge clk);
      #1 sgn = 1'b0;
      issue(8'h9C, 8'd7);
      wait_done(lat, bcnt);
      chk("u_9c_q", Quotient, 22);
      chk("u_9c_r", Remainder, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
